// File: rtl/fp_widen_convert.sv
// IEEE-754 widening converter (default binary32 -> binary64) with valid/ready handshakes.
// Subnormal inputs are normalised one bit per cycle; results are exact, no rounding.
module fp_widen_convert #(
    parameter int IN_EXP  = 8,
    parameter int IN_MAN  = 23,
    parameter int OUT_EXP = 11,
    parameter int OUT_MAN = 52,
    parameter int CNT_W   = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_EXP+IN_MAN:0]       in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_EXP+OUT_MAN:0]     out_data,
    output logic                         nan_exception,
    output logic [1:0]                   dbg_state
);

    localparam int BIAS_IN  = (1 << (IN_EXP - 1)) - 1;
    localparam int BIAS_OUT = (1 << (OUT_EXP - 1)) - 1;
    localparam int PAD      = OUT_MAN - IN_MAN;
    localparam logic [OUT_EXP-1:0] NORM_OFF = OUT_EXP'(BIAS_OUT - BIAS_IN);
    localparam logic [OUT_EXP-1:0] SUB_BASE = OUT_EXP'(BIAS_OUT + 1 - BIAS_IN);
    localparam logic [IN_MAN-1:0]  QBIT     = {1'b1, {(IN_MAN-1){1'b0}}};

    // Handshake rule: a transfer happens on a rising edge where valid and ready are both 1;
    // a producer holding valid keeps its data stable until that edge.
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_NORM, S_OUTPUT} state_t;

    state_t                      state_q, state_d;
    logic                        sign_q, sign_d;
    logic [IN_EXP-1:0]           exp_q, exp_d;
    logic [IN_MAN-1:0]           frac_q, frac_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [OUT_EXP+OUT_MAN:0]    out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;
    logic                        nan_q, nan_d;
    logic [OUT_MAN-1:0]          frac_wide;

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        frac_d      = frac_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        nan_d       = nan_q;
        frac_wide   = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_data[IN_EXP+IN_MAN];
                    exp_d   = in_data[IN_MAN +: IN_EXP];
                    frac_d  = in_data[IN_MAN-1:0];
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_OUTPUT;
                if (exp_q == '1) begin
                    // NaNs are quieted by forcing the fraction MSB; payload is kept.
                    frac_wide  = (frac_q == '0) ? '0 : (OUT_MAN'(frac_q | QBIT) << PAD);
                    out_data_d = {sign_q, {OUT_EXP{1'b1}}, frac_wide};
                    nan_d      = (frac_q != '0) && !frac_q[IN_MAN-1];
                end else if (exp_q == '0) begin
                    if (frac_q == '0) begin
                        out_data_d = {sign_q, {(OUT_EXP+OUT_MAN){1'b0}}};
                    end else begin
                        cnt_d   = '0;
                        state_d = S_NORM;
                    end
                end else begin
                    frac_wide  = OUT_MAN'(frac_q) << PAD;
                    out_data_d = {sign_q, OUT_EXP'(exp_q) + NORM_OFF, frac_wide};
                end
            end
            S_NORM: begin
                frac_d = frac_q << 1;
                cnt_d  = cnt_q + 1'b1;
                // The bit leaving the MSB is the implicit leading one.
                if (frac_q[IN_MAN-1]) begin
                    frac_wide  = OUT_MAN'(frac_d) << PAD;
                    out_data_d = {sign_q, SUB_BASE - OUT_EXP'(cnt_d), frac_wide};
                    state_d    = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    nan_d       = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            frac_q      <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            nan_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            frac_q      <= frac_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            nan_q       <= nan_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign nan_exception = nan_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fp_widen_convert.sv
// Bench for fp_widen_convert: directed test-plan vectors, backpressure, mid-op reset,
// and randomized operands checked against an arithmetic float-to-double model.
module tb_fp_widen_convert;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        nan_exception;
    logic [1:0]  dbg_state;

    logic [63:0] exp_q[$];
    logic        exp_nan_q[$];
    int          exp_lat_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    fp_widen_convert dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .nan_exception(nan_exception), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Float-to-double by value: unbiased exponent and significand, re-biased for binary64.
    function automatic void ref_model(input logic [31:0] x, output logic [63:0] y,
                                      output logic nan, output int lat);
        logic        s;
        int          e;
        int          p;
        logic [22:0] f;
        logic [51:0] m;
        s = x[31];
        e = int'(x[30:23]);
        f = x[22:0];
        nan = 1'b0;
        lat = 2;
        p = 0;
        if (e == 255) begin
            if (f == 0) begin
                y = {s, 11'h7FF, 52'h0};
            end else begin
                nan = !f[22];
                y = {s, 11'h7FF, f | 23'h400000, 29'h0};
            end
        end else if (e == 0 && f == 0) begin
            y = {s, 63'h0};
        end else if (e == 0) begin
            for (int i = 0; i < 23; i++) if (f[i]) p = i;
            // value = 1.m * 2^(p-149)
            m = 52'(f) << (52 - p);
            y = {s, 11'(p - 149 + 1023), m};
            lat = 2 + (23 - p);
        end else begin
            y = {s, 11'(e - 127 + 1023), f, 29'h0};
        end
    endfunction

    task automatic accept(input logic [31:0] d, input logic [63:0] e, input logic en, input int lat);
        int w;
        w = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("accept_timeout", 64'(w < 200), 64'd1);
        exp_q.push_back(e);
        exp_nan_q.push_back(en);
        exp_lat_q.push_back(lat);
    endtask

    task automatic await_result();
        int lat;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("out_valid_seen", 64'(out_valid), 64'd1);
        check_eq("latency", 64'(lat), 64'(exp_lat_q.pop_front()));
        check_eq("out_data", out_data, exp_q.pop_front());
        check_eq("nan_exception", 64'(nan_exception), 64'(exp_nan_q.pop_front()));
    endtask

    task automatic release_out(input int hold);
        logic [63:0] held_d;
        logic        held_n;
        held_d = out_data;
        held_n = nan_exception;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_data", out_data, held_d);
            check_eq("hold_nan", 64'(nan_exception), 64'(held_n));
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("post_hs_valid", 64'(out_valid), 64'd0);
        check_eq("post_hs_nan", 64'(nan_exception), 64'd0);
        check_eq("post_hs_data", out_data, held_d);
        check_eq("post_hs_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic directed(input logic [31:0] d, input logic [63:0] e, input logic en, input int lat);
        @(negedge clk);
        accept(d, e, en, lat);
        await_result();
        release_out(0);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [22:0] f;
        logic        s;
        s = 1'(($urandom() & 1));
        f = 23'($urandom());
        case ($urandom_range(0, 5))
            0: return {s, 8'(($urandom_range(1, 254))), f};
            1: begin
                f = f >> $urandom_range(0, 22);
                if (f == 0) f = 23'd1;
                return {s, 8'h00, f};
            end
            2: return {s, 31'h0};
            3: return {s, 8'hFF, 23'h0};
            4: return {s, 8'hFF, f | 23'h400000};
            default: return {s, 8'hFF, 23'($urandom_range(1, 23'h3FFFFF))};
        endcase
    endfunction

    initial begin
        logic [31:0] d;
        logic [63:0] e;
        logic        en;
        int          lat;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);
        check_eq("rst_nan", 64'(nan_exception), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;

        directed(32'h3F800000, 64'h3FF0000000000000, 1'b0, 2);
        directed(32'hC0490FDB, 64'hC00921FB60000000, 1'b0, 2);
        directed(32'h7F800001, 64'h7FF8000020000000, 1'b1, 2);
        directed(32'h7FC00000, 64'h7FF8000000000000, 1'b0, 2);
        directed(32'hFF800000, 64'hFFF0000000000000, 1'b0, 2);
        directed(32'h80000000, 64'h8000000000000000, 1'b0, 2);
        directed(32'h00000000, 64'h0000000000000000, 1'b0, 2);
        directed(32'h00000001, 64'h36A0000000000000, 1'b0, 25);
        directed(32'h00400000, 64'h3800000000000000, 1'b0, 3);
        directed(32'h807FFFFF, 64'hB80FFFFFC0000000, 1'b0, 3);

        // Backpressure with a second operand already waiting on the input.
        @(negedge clk);
        accept(32'h7F800001, 64'h7FF8000020000000, 1'b1, 2);
        await_result();
        in_data  = 32'hC0490FDB;
        in_valid = 1'b1;
        release_out(5);
        accept(32'hC0490FDB, 64'hC00921FB60000000, 1'b0, 2);
        await_result();
        release_out(0);

        // Reset while normalising a subnormal: nothing may come out of it.
        @(negedge clk);
        accept(32'h00000001, 64'h36A0000000000000, 1'b0, 25);
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_out_data", out_data, 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        exp_nan_q.delete();
        exp_lat_q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("midrst_no_output", 64'(out_valid), 64'd0);
        directed(32'h3F800000, 64'h3FF0000000000000, 1'b0, 2);

        for (int n = 0; n < 60; n++) begin
            d = rand_operand();
            ref_model(d, e, en, lat);
            @(negedge clk);
            accept(d, e, en, lat);
            await_result();
            release_out($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
